softreg_bridge: RTL and testbench

//  Decoupling stage between the shell SoftRegReq/SoftRegResp ports of each app wrapper and its program_logic.

---
 rtl/softreg_bridge_pkg.sv | 27 ++
 rtl/softreg_bridge_fifo.sv | 59 +++++
 rtl/softreg_bridge.sv | 152 +++++++++++++++
 tb/tb_softreg_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softreg_bridge_pkg.sv
// Shared types for the softreg decoupling bridge: FSM states, queued request layout,
// timeout fill pattern and a saturating counter helper.
package softreg_bridge_pkg;

  localparam int SRB_ADDR_W = 32;
  localparam int SRB_DATA_W = 64;

  localparam logic [63:0] SRB_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {
    SRB_IDLE,
    SRB_ISSUE,
    SRB_WAIT_RESP
  } SRBState;

  typedef struct packed {
    logic                  isWrite;
    logic [SRB_ADDR_W-1:0] addr;
    logic [SRB_DATA_W-1:0] data;
  } SRBEntry;

  // Status counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] srb_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/softreg_bridge_fifo.sv
// Synchronous request FIFO with a registered read port; the read register doubles as the
// bridge's issue register, so the head stays stable until the next pop.
module softreg_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign pop_data_o = rd_data_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        rd_data_q <= mem_q[rd_ptr_q[PTR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/softreg_bridge.sv
// Decouples shell softreg traffic (no backpressure) from program_logic: requests are queued,
// issued one at a time over valid/ready, and a silent read is completed with a fill pattern.
module softreg_bridge
  import softreg_bridge_pkg::*;
#(
  parameter int                ADDR_W       = SRB_ADDR_W,
  parameter int                DATA_W       = SRB_DATA_W,
  parameter int                FIFO_DEPTH   = 16,
  parameter int                TIMEOUT      = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(SRB_TIMEOUT_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_req_valid,
  input  logic              up_req_isWrite,
  input  logic [ADDR_W-1:0] up_req_addr,
  input  logic [DATA_W-1:0] up_req_data,
  output logic              up_resp_valid,
  output logic [DATA_W-1:0] up_resp_data,
  output logic              dn_req_valid,
  input  logic              dn_req_ready,
  output logic              dn_req_isWrite,
  output logic [ADDR_W-1:0] dn_req_addr,
  output logic [DATA_W-1:0] dn_req_data,
  input  logic              dn_resp_valid,
  input  logic [DATA_W-1:0] dn_resp_data,
  output logic              overflow_sticky,
  output logic [15:0]       drop_count,
  output logic [15:0]       timeout_count
);

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  SRBState           state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              sticky_q;
  logic [15:0]       drop_cnt_q;
  logic [15:0]       to_cnt_q;

  entry_t push_entry;
  entry_t head_entry;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_pop;
  logic   timed_out;

  assign push_entry.is_write = up_req_isWrite;
  assign push_entry.addr     = up_req_addr;
  assign push_entry.data     = up_req_data;

  softreg_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (up_req_valid),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .pop_data_o (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    fifo_pop     = 1'b0;
    timed_out    = 1'b0;
    unique case (state_q)
      SRB_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = SRB_ISSUE;
        end
      end
      SRB_ISSUE: begin
        if (dn_req_ready) begin
          if (head_entry.is_write) begin
            state_d = SRB_IDLE;
          end else begin
            state_d = SRB_WAIT_RESP;
            timer_d = '0;
          end
        end
      end
      SRB_WAIT_RESP: begin
        timer_d = timer_q + TMR_ONE;
        // A real response arriving in the last wait cycle still beats the timeout.
        if (dn_resp_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = dn_resp_data;
          state_d      = SRB_IDLE;
        end else if (timer_q == TMR_LAST) begin
          resp_valid_d = 1'b1;
          resp_data_d  = TIMEOUT_DATA;
          timed_out    = 1'b1;
          state_d      = SRB_IDLE;
        end
      end
      default: state_d = SRB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SRB_IDLE;
      timer_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      sticky_q     <= 1'b0;
      drop_cnt_q   <= '0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      // Fullness is judged before any same-cycle pop.
      if (up_req_valid && fifo_full) begin
        sticky_q   <= 1'b1;
        drop_cnt_q <= srb_sat_inc(drop_cnt_q);
      end
      if (timed_out) begin
        to_cnt_q <= srb_sat_inc(to_cnt_q);
      end
    end
  end

  assign dn_req_valid    = (state_q == SRB_ISSUE);
  assign dn_req_isWrite  = head_entry.is_write;
  assign dn_req_addr     = head_entry.addr;
  assign dn_req_data     = head_entry.data;
  assign up_resp_valid   = resp_valid_q;
  assign up_resp_data    = resp_data_q;
  assign overflow_sticky = sticky_q;
  assign drop_count      = drop_cnt_q;
  assign timeout_count   = to_cnt_q;

endmodule

// File: tb/tb_softreg_bridge.sv
// Bench for softreg_bridge: directed scenarios plus a randomized mix, checked against a
// queue-based model of expected downstream requests and upstream completions.
module tb_softreg_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int TMO    = 8;
  localparam logic [63:0] TMO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst;
  logic              up_req_valid;
  logic              up_req_isWrite;
  logic [ADDR_W-1:0] up_req_addr;
  logic [DATA_W-1:0] up_req_data;
  logic              up_resp_valid;
  logic [DATA_W-1:0] up_resp_data;
  logic              dn_req_valid;
  logic              dn_req_ready;
  logic              dn_req_isWrite;
  logic [ADDR_W-1:0] dn_req_addr;
  logic [DATA_W-1:0] dn_req_data;
  logic              dn_resp_valid;
  logic [DATA_W-1:0] dn_resp_data;
  logic              overflow_sticky;
  logic [15:0]       drop_count;
  logic [15:0]       timeout_count;

  softreg_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT     (TMO),
    .TIMEOUT_DATA(TMO_DATA)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .up_req_valid   (up_req_valid),
    .up_req_isWrite (up_req_isWrite),
    .up_req_addr    (up_req_addr),
    .up_req_data    (up_req_data),
    .up_resp_valid  (up_resp_valid),
    .up_resp_data   (up_resp_data),
    .dn_req_valid   (dn_req_valid),
    .dn_req_ready   (dn_req_ready),
    .dn_req_isWrite (dn_req_isWrite),
    .dn_req_addr    (dn_req_addr),
    .dn_req_data    (dn_req_data),
    .dn_resp_valid  (dn_resp_valid),
    .dn_resp_data   (dn_resp_data),
    .overflow_sticky(overflow_sticky),
    .drop_count     (drop_count),
    .timeout_count  (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    logic [63:0] data;
    int          due;
    bit          is_to;
  } resp_t;

  req_t  exp_dn[$];
  resp_t exp_up[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int ncyc       = 0;
  int up_pulses  = 0;
  int n_accept   = 0;
  int model_to   = 0;
  int ready_mode = 1;
  int resp_lo    = 1;
  int resp_hi    = 1;
  bit fix_en     = 1'b0;
  logic [63:0] fix_data = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit w, input logic [31:0] a, input logic [63:0] dat, input bit admitted);
    req_t r;
    @(negedge clk);
    up_req_valid   = 1'b1;
    up_req_isWrite = w;
    up_req_addr    = a;
    up_req_data    = dat;
    $display("REQ %s addr=%h data=%h%s", w ? "WR" : "RD", a, dat, admitted ? "" : " (dropped)");
    if (admitted) begin
      r.is_write = w;
      r.addr     = a;
      r.data     = dat;
      exp_dn.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      up_req_valid = 1'b0;
    end
  endtask

  // Behaves as program_logic and scoreboards both sides of the bridge, once per cycle.
  initial begin : pl_model
    int          d;
    int          resp_cd;
    logic [63:0] rv;
    logic [63:0] resp_val;
    req_t        r;
    resp_t       e;
    resp_cd       = 0;
    resp_val      = '0;
    dn_req_ready  = 1'b0;
    dn_resp_valid = 1'b0;
    dn_resp_data  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      dn_resp_valid = 1'b0;
      if (rst) begin
        exp_dn.delete();
        exp_up.delete();
        resp_cd      = 0;
        dn_req_ready = 1'b0;
      end else begin
        if (up_resp_valid) begin
          up_pulses++;
          $display("RESP data=%h cycle=%0d", up_resp_data, ncyc);
          if (exp_up.size() == 0) begin
            chk("up_resp_unexpected", 1, 0);
          end else begin
            e = exp_up.pop_front();
            chk("up_resp_data", up_resp_data, e.data);
            chk("up_resp_cycle", ncyc, e.due);
            if (e.is_to) model_to++;
          end
        end else if (exp_up.size() != 0 && exp_up[0].due <= ncyc) begin
          chk("up_resp_missing", 0, 1);
          e = exp_up.pop_front();
        end

        if (resp_cd > 0) begin
          resp_cd--;
          if (resp_cd == 0) begin
            dn_resp_valid = 1'b1;
            dn_resp_data  = resp_val;
          end
        end

        case (ready_mode)
          0:       dn_req_ready = 1'b0;
          1:       dn_req_ready = 1'b1;
          default: dn_req_ready = 1'($urandom_range(0, 1));
        endcase

        if (dn_req_valid && dn_req_ready) begin
          n_accept++;
          if (exp_dn.size() == 0) begin
            chk("dn_unexpected", 1, 0);
          end else begin
            r = exp_dn.pop_front();
            chk("dn_isWrite", dn_req_isWrite, r.is_write);
            chk("dn_addr", dn_req_addr, r.addr);
            chk("dn_data", dn_req_data, r.data);
            if (!r.is_write) begin
              // d cycles after accept program_logic answers; d==0 means never, d>TMO arrives too late.
              d  = int'($urandom_range(resp_lo, resp_hi));
              rv = fix_en ? fix_data : {$urandom, $urandom};
              if (d >= 1 && d <= TMO) begin
                e.data  = rv;
                e.due   = ncyc + d + 1;
                e.is_to = 1'b0;
              end else begin
                e.data  = TMO_DATA;
                e.due   = ncyc + TMO + 1;
                e.is_to = 1'b1;
              end
              exp_up.push_back(e);
              if (d > 0) begin
                resp_cd  = d;
                resp_val = rv;
              end
            end
          end
        end
      end
    end
  end

  initial begin : main_seq
    int p0;
    int a0;
    int nreads;
    bit w;
    rst            = 1'b1;
    up_req_valid   = 1'b0;
    up_req_isWrite = 1'b0;
    up_req_addr    = '0;
    up_req_data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_up_resp_valid", up_resp_valid, 0);
    chk("rst_up_resp_data", up_resp_data, 0);
    chk("rst_dn_req_valid", dn_req_valid, 0);
    chk("rst_dn_req_fields", {dn_req_isWrite, dn_req_addr, dn_req_data}, 0);
    chk("rst_sticky", overflow_sticky, 0);
    chk("rst_counters", {drop_count, timeout_count}, 0);
    rst = 1'b0;

    // Single write: issued two cycles after arrival, no upstream response.
    ready_mode = 1;
    idle(2);
    p0 = up_pulses;
    put(1'b1, 32'h10, 64'h1234, 1'b1);
    @(negedge clk);
    up_req_valid = 1'b0;
    chk("t1_valid_n1", dn_req_valid, 0);
    @(negedge clk);
    chk("t1_valid_n2", dn_req_valid, 1);
    chk("t1_isWrite", dn_req_isWrite, 1);
    chk("t1_addr", dn_req_addr, 32'h10);
    chk("t1_data", dn_req_data, 64'h1234);
    idle(6);
    chk("t1_no_resp", up_pulses, p0);

    // Read answered three cycles after accept.
    resp_lo  = 3;
    resp_hi  = 3;
    fix_en   = 1'b1;
    fix_data = 64'hCAFE;
    p0 = up_pulses;
    put(1'b0, 32'h20, 64'h0, 1'b1);
    idle(14);
    chk("t2_pulses", up_pulses - p0, 1);
    fix_en = 1'b0;

    // Overflow: one request parked in ISSUE, then 20 back-to-back with ready low.
    ready_mode = 0;
    chk("t3_sticky_before", overflow_sticky, 0);
    put(1'b1, 32'h100, {$urandom, $urandom}, 1'b1);
    idle(3);
    for (int i = 0; i < 20; i++) begin
      put(1'b1, 32'h200 + 32'(i), {$urandom, $urandom}, i < DEPTH);
    end
    idle(2);
    chk("t3_drop_count", drop_count, 4);
    chk("t3_sticky", overflow_sticky, 1);
    ready_mode = 1;
    idle(40);
    chk("t3_all_issued", exp_dn.size(), 0);

    // Silent read times out; the late answer must not produce a second pulse.
    resp_lo = 12;
    resp_hi = 12;
    p0 = up_pulses;
    put(1'b0, 32'h30, 64'h0, 1'b1);
    idle(30);
    chk("t4_timeout_count", timeout_count, 1);
    chk("t4_pulses", up_pulses - p0, 1);

    // Random mix with stalls, response delays spanning the timeout boundary.
    ready_mode = 2;
    resp_lo    = 1;
    resp_hi    = 9;
    nreads     = 0;
    p0 = up_pulses;
    for (int i = 0; i < 14; i++) begin
      w = 1'($urandom_range(0, 1));
      put(w, $urandom, {$urandom, $urandom}, 1'b1);
      if (!w) nreads++;
      idle(int'($urandom_range(0, 3)));
    end
    idle(400);
    chk("t5_dn_drained", exp_dn.size(), 0);
    chk("t5_up_drained", exp_up.size(), 0);
    chk("t5_pulses", up_pulses - p0, nreads);
    chk("t5_timeout_count", timeout_count, model_to);
    chk("t5_drop_count", drop_count, 4);

    // Reset while a read is outstanding and three requests are queued.
    ready_mode = 1;
    resp_lo    = 0;
    resp_hi    = 0;
    put(1'b0, 32'h40, 64'h0, 1'b1);
    idle(3);
    put(1'b1, 32'h41, {$urandom, $urandom}, 1'b1);
    put(1'b0, 32'h42, {$urandom, $urandom}, 1'b1);
    put(1'b1, 32'h43, {$urandom, $urandom}, 1'b1);
    @(negedge clk);
    up_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_up_resp_valid", up_resp_valid, 0);
    chk("t6_up_resp_data", up_resp_data, 0);
    chk("t6_dn_req", {dn_req_valid, dn_req_isWrite, dn_req_addr, dn_req_data}, 0);
    chk("t6_status", {overflow_sticky, drop_count, timeout_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = up_pulses;
    a0 = n_accept;
    idle(30);
    chk("t6_no_resp", up_pulses, p0);
    chk("t6_no_issue", n_accept, a0);
    chk("t6_dn_idle", dn_req_valid, 0);
    chk("t6_timeout_count", timeout_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
